// File: rtl/miter_seq_cmp.sv
// miter_seq_cmp: windowed gold-vs-gate comparator with gold-side alignment delay, don't-care masking,
// sticky per-channel fail flags, first-fail capture and saturating mismatch count. Option macro: MITER_STOP_ON_FAIL_EN.
module miter_seq_cmp #(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 4,
  parameter int  DELAY    = 2,
  parameter int  CNT_W    = 16,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int DW       = CHANNELS * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] window,
  input  logic             valid_in,
  input  logic [DW-1:0]    gold_in,
  input  logic [DW-1:0]    xmask_in,
  input  logic [DW-1:0]    gate_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CHANNELS-1:0] fail_chan,
  output logic [CNT_W-1:0] first_fail_cycle,
  output logic [CH_W-1:0]  first_fail_chan,
  output logic [15:0]      mismatch_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    window_q, window_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic                pass_q, pass_d;
  logic [CHANNELS-1:0] fail_q, fail_d;
  logic [CNT_W-1:0]    ffc_q, ffc_d;
  logic [CH_W-1:0]     ffch_q, ffch_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                clr_pipe;
  logic                dvalid;
  logic [DW-1:0]       dgold;
  logic [DW-1:0]       dmask;
  logic [CHANNELS-1:0] miss;
  logic                any_miss;
  logic [CH_W-1:0]     low_ch;
  logic                last_beat;

  // Gold-side alignment: valid, data and mask travel together so gate_in meets the matching gold beat.
  generate
    if (DELAY == 0) begin : g_nodly
      assign dvalid = valid_in;
      assign dgold  = gold_in;
      assign dmask  = xmask_in;
    end else begin : g_dly
      logic          v_q [DELAY];
      logic [DW-1:0] g_q [DELAY];
      logic [DW-1:0] m_q [DELAY];

      always_ff @(posedge clk) begin
        if (rst || clr_pipe) begin
          for (int i = 0; i < DELAY; i++) begin
            v_q[i] <= 1'b0;
          end
        end else begin
          v_q[0] <= valid_in;
          for (int i = 1; i < DELAY; i++) begin
            v_q[i] <= v_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        g_q[0] <= gold_in;
        m_q[0] <= xmask_in;
        for (int i = 1; i < DELAY; i++) begin
          g_q[i] <= g_q[i-1];
          m_q[i] <= m_q[i-1];
        end
      end

      assign dvalid = v_q[DELAY-1];
      assign dgold  = g_q[DELAY-1];
      assign dmask  = m_q[DELAY-1];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_miss
      assign miss[gi] = |((dgold[gi*WIDTH +: WIDTH] ^ gate_in[gi*WIDTH +: WIDTH])
                          & ~dmask[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  assign any_miss = |miss;

  always_comb begin
    low_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (miss[i]) begin
        low_ch = CH_W'(i);
      end
    end
  end

  always_comb begin
    last_beat = (beat_q == (window_q - CNT_W'(1)));
`ifdef MITER_STOP_ON_FAIL_EN
    last_beat = last_beat || any_miss;
`endif
  end

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    beat_d   = beat_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ffc_d    = ffc_q;
    ffch_d   = ffch_q;
    cnt_d    = cnt_q;
    clr_pipe = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr_pipe = 1'b1;
          window_d = window;
          beat_d   = '0;
          fail_d   = '0;
          ffc_d    = '0;
          ffch_d   = '0;
          cnt_d    = '0;
          // An empty window finishes immediately as a trivial pass.
          if (window == '0) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            pass_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (dvalid) begin
          fail_d = fail_q | miss;
          if (any_miss && (fail_q == '0)) begin
            ffc_d  = beat_q;
            ffch_d = low_ch;
          end
          if (any_miss && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
          end
          beat_d = beat_q + CNT_W'(1);
          if (last_beat) begin
            state_d = S_DONE;
            pass_d  = ((fail_q | miss) == '0);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      window_q <= '0;
      beat_q   <= '0;
      pass_q   <= 1'b0;
      fail_q   <= '0;
      ffc_q    <= '0;
      ffch_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      beat_q   <= beat_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ffc_q    <= ffc_d;
      ffch_q   <= ffch_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign fail_chan        = fail_q;
  assign first_fail_cycle = ffc_q;
  assign first_fail_chan  = ffch_q;
  assign mismatch_count   = cnt_q;

endmodule

// File: tb/tb_miter_seq_cmp.sv
// Randomised bench for miter_seq_cmp: a per-beat reference model computes expected results from injected error patterns.
module tb_miter_seq_cmp;
  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int DLY = 2;
  localparam int CW  = 17;
  localparam int DW  = CH * W;
`ifdef MITER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] window;
  logic          valid_in;
  logic [DW-1:0] gold_in, xmask_in, gate_in;
  logic          busy, done, pass;
  logic [CH-1:0] fail_chan;
  logic [CW-1:0] first_fail_cycle;
  logic [1:0]    first_fail_chan;
  logic [15:0]   mismatch_count;

  miter_seq_cmp #(.WIDTH(W), .CHANNELS(CH), .DELAY(DLY), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .window(window), .valid_in(valid_in),
    .gold_in(gold_in), .xmask_in(xmask_in), .gate_in(gate_in),
    .busy(busy), .done(done), .pass(pass), .fail_chan(fail_chan),
    .first_fail_cycle(first_fail_cycle), .first_fail_chan(first_fail_chan),
    .mismatch_count(mismatch_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Per-beat error and mask tables for directed runs, indexed by beat number.
  logic [DW-1:0] err_tab [64];
  logic [DW-1:0] msk_tab [64];

  // Recent input history, indexed by cycle modulo 16.
  logic          h_v    [16];
  logic [DW-1:0] h_gold [16];
  logic [DW-1:0] h_mask [16];

  // Model results and observations from the latest run.
  logic          m_pass;
  logic [CH-1:0] m_fail;
  logic [CW-1:0] m_ffc;
  logic [1:0]    m_ffch;
  logic [15:0]   m_cnt;
  int            fin_t, done_t, bad_run;
  logic [CH-1:0] obs0_fail;
  logic [15:0]   obs0_cnt;

  task automatic clear_tabs();
    for (int i = 0; i < 64; i++) begin
      err_tab[i] = '0;
      msk_tab[i] = '0;
    end
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random. emode: 0 none, 1 tables, 2 random, 3 ch0 bit0 every beat.
  task automatic run(input int w, input int vmode, input int emode, input bit poke_start);
    int t, k, in_k, lim, slot;
    bit running, v;
    logic [DW-1:0] g, m, e, em;
    logic [CH-1:0] miss;
    m_fail = '0; m_ffc = '0; m_ffch = '0; m_cnt = '0;
    fin_t = -1; done_t = -1; bad_run = 0;
    obs0_fail = '0; obs0_cnt = '0;
    for (int i = 0; i < 16; i++) h_v[i] = 1'b0;
    start = 1'b1; window = CW'(w); valid_in = 1'b1;
    gold_in = $urandom; xmask_in = '0; gate_in = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0; k = 0; in_k = 0;
    running = (w != 0);
    lim = w * 4 + 40;
    while (t < lim) begin
      if (done_t < 0 && done) done_t = t;
      if (running && (done || !busy)) bad_run++;
      if (t == 0) begin
        obs0_fail = fail_chan;
        obs0_cnt  = mismatch_count;
      end
      if (!running && t > fin_t) break;
      case (vmode)
        0: v = 1'b1;
        1: v = (t % 2 == 0);
        default: v = $urandom_range(0, 1) == 1;
      endcase
      g = $urandom;
      case (emode)
        1: m = msk_tab[in_k % 64];
        2: m = $urandom & $urandom & $urandom;
        default: m = '0;
      endcase
      if (v) in_k++;
      h_v[t % 16] = v; h_gold[t % 16] = g; h_mask[t % 16] = m;
      valid_in = v; gold_in = g; xmask_in = m;
      if (poke_start && t == 2) begin
        start = 1'b1; window = CW'(1);
      end else begin
        start = 1'b0;
      end
      slot = (t - DLY) % 16;
      if (running && t >= DLY && h_v[slot]) begin
        case (emode)
          1: e = err_tab[k % 64];
          2: e = ($urandom_range(0, 2) == 0) ? DW'($urandom) : '0;
          3: e = DW'(1);
          default: e = '0;
        endcase
        gate_in = h_gold[slot] ^ e;
        em = e & ~h_mask[slot];
        for (int c = 0; c < CH; c++) miss[c] = |em[c*W +: W];
        if (miss != '0) begin
          if (m_fail == '0) begin
            m_ffc = CW'(k);
            for (int c = CH - 1; c >= 0; c--) if (miss[c]) m_ffch = 2'(c);
          end
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        m_fail = m_fail | miss;
        k++;
        if (k == w || (STOP && miss != '0)) begin
          running = 1'b0;
          fin_t = t;
        end
      end else begin
        gate_in = $urandom;
      end
      @(posedge clk); #1;
      t++;
    end
    if (running) bad_run++;
    m_pass = (m_fail == '0);
    start = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; window = '0; valid_in = 1'b0;
    gold_in = '0; xmask_in = '0; gate_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({busy, done, pass} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {busy, done, pass}); end
    n_vec++; if (fail_chan !== '0 || mismatch_count !== '0) begin n_err++; $display("FAIL reset_results fail=%b cnt=%0d exp 0/0", fail_chan, mismatch_count); end
    n_vec++; if (first_fail_cycle !== '0 || first_fail_chan !== '0) begin n_err++; $display("FAIL reset_first cyc=%0d ch=%0d exp 0/0", first_fail_cycle, first_fail_chan); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: outputs idle");
  endtask

  task automatic test_clean();
    clear_tabs();
    run(10, 0, 0, 1'b0);
    n_vec++; if (done_t !== fin_t + 1) begin n_err++; $display("FAIL clean_done_cycle got=%0d exp=%0d", done_t, fin_t + 1); end
    n_vec++; if (bad_run !== 0) begin n_err++; $display("FAIL clean_busy got=%0d exp=0", bad_run); end
    n_vec++; if (pass !== 1'b1 || fail_chan !== '0) begin n_err++; $display("FAIL clean_pass pass=%b fail=%b exp 1/0000", pass, fail_chan); end
    n_vec++; if (mismatch_count !== 16'd0) begin n_err++; $display("FAIL clean_count got=%0d exp=0", mismatch_count); end
    $display("clean: window=10 done_t=%0d pass=%b", done_t, pass);
  endtask

  task automatic test_flips();
    clear_tabs();
    err_tab[4] = DW'(1) << (2 * W + 3);
    err_tab[7] = DW'(1) << (1 * W + 5);
    run(10, 0, 1, 1'b0);
    n_vec++; if (pass !== m_pass) begin n_err++; $display("FAIL flips_pass got=%b exp=%b", pass, m_pass); end
    n_vec++; if (fail_chan !== m_fail) begin n_err++; $display("FAIL flips_fail_chan got=%b exp=%b", fail_chan, m_fail); end
    n_vec++; if (first_fail_cycle !== m_ffc || first_fail_chan !== m_ffch) begin n_err++; $display("FAIL flips_first got=%0d/%0d exp=%0d/%0d", first_fail_cycle, first_fail_chan, m_ffc, m_ffch); end
    n_vec++; if (mismatch_count !== m_cnt) begin n_err++; $display("FAIL flips_count got=%0d exp=%0d", mismatch_count, m_cnt); end
    n_vec++; if (done_t !== fin_t + 1) begin n_err++; $display("FAIL flips_done_cycle got=%0d exp=%0d", done_t, fin_t + 1); end
    $display("flips: fail_chan=%b first=%0d/%0d count=%0d", fail_chan, first_fail_cycle, first_fail_chan, mismatch_count);
  endtask

  task automatic test_xmask();
    clear_tabs();
    err_tab[3] = DW'(1) << 2;
    msk_tab[3] = DW'(1) << 2;
    run(10, 0, 1, 1'b0);
    n_vec++; if (pass !== 1'b1 || mismatch_count !== 16'd0) begin n_err++; $display("FAIL xmask_pass pass=%b cnt=%0d exp 1/0", pass, mismatch_count); end
    clear_tabs();
    err_tab[5] = (DW'(1) << 1) | (DW'(1) << (3 * W + 6));
    run(8, 0, 1, 1'b0);
    n_vec++; if (first_fail_chan !== m_ffch || first_fail_cycle !== m_ffc) begin n_err++; $display("FAIL same_beat_first got=%0d/%0d exp=%0d/%0d", first_fail_cycle, first_fail_chan, m_ffc, m_ffch); end
    n_vec++; if (fail_chan !== m_fail) begin n_err++; $display("FAIL same_beat_fail_chan got=%b exp=%b", fail_chan, m_fail); end
    $display("xmask: same-beat first_fail_chan=%0d fail_chan=%b", first_fail_chan, fail_chan);
  endtask

  task automatic test_window0();
    run(0, 0, 0, 1'b0);
    n_vec++; if (done_t !== 0) begin n_err++; $display("FAIL window0_done_cycle got=%0d exp=0", done_t); end
    n_vec++; if (pass !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL window0_pass pass=%b busy=%b exp 1/0", pass, busy); end
    $display("window0: done_t=%0d pass=%b", done_t, pass);
  endtask

  task automatic test_valid_toggle();
    clear_tabs();
    run(5, 1, 0, 1'b0);
    n_vec++; if (done_t !== fin_t + 1) begin n_err++; $display("FAIL toggle_done_cycle got=%0d exp=%0d", done_t, fin_t + 1); end
    n_vec++; if (pass !== 1'b1 || bad_run !== 0) begin n_err++; $display("FAIL toggle_pass pass=%b bad=%0d exp 1/0", pass, bad_run); end
    $display("toggle: window=5 done_t=%0d", done_t);
  endtask

  task automatic test_start_in_run();
    run(12, 0, 2, 1'b1);
    n_vec++; if (done_t !== fin_t + 1) begin n_err++; $display("FAIL start_in_run_done got=%0d exp=%0d", done_t, fin_t + 1); end
    n_vec++; if (mismatch_count !== m_cnt || fail_chan !== m_fail) begin n_err++; $display("FAIL start_in_run_results cnt=%0d fail=%b exp %0d/%b", mismatch_count, fail_chan, m_cnt, m_fail); end
    $display("start_in_run: done_t=%0d count=%0d", done_t, mismatch_count);
  endtask

  task automatic test_random();
    int w;
    for (int r = 0; r < 8; r++) begin
      w = $urandom_range(1, 40);
      run(w, 2, 2, 1'b0);
      n_vec++; if (done_t !== fin_t + 1 || bad_run !== 0) begin n_err++; $display("FAIL rand%0d_timing done_t=%0d exp=%0d bad=%0d", r, done_t, fin_t + 1, bad_run); end
      n_vec++; if (pass !== m_pass || fail_chan !== m_fail) begin n_err++; $display("FAIL rand%0d_pass pass=%b fail=%b exp %b/%b", r, pass, fail_chan, m_pass, m_fail); end
      n_vec++; if (first_fail_cycle !== m_ffc || first_fail_chan !== m_ffch) begin n_err++; $display("FAIL rand%0d_first got=%0d/%0d exp=%0d/%0d", r, first_fail_cycle, first_fail_chan, m_ffc, m_ffch); end
      n_vec++; if (mismatch_count !== m_cnt) begin n_err++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, mismatch_count, m_cnt); end
      $display("random %0d: window=%0d pass=%b fail_chan=%b count=%0d", r, w, pass, fail_chan, mismatch_count);
    end
  endtask

  task automatic test_back_to_back();
    run(6, 0, 3, 1'b0);
    n_vec++; if (pass !== m_pass || mismatch_count !== m_cnt) begin n_err++; $display("FAIL b2b_first pass=%b cnt=%0d exp %b/%0d", pass, mismatch_count, m_pass, m_cnt); end
    run(6, 0, 0, 1'b0);
    n_vec++; if (obs0_fail !== '0 || obs0_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_clear fail=%b cnt=%0d exp 0/0", obs0_fail, obs0_cnt); end
    n_vec++; if (pass !== 1'b1 || done_t !== fin_t + 1) begin n_err++; $display("FAIL b2b_second pass=%b done_t=%0d exp 1/%0d", pass, done_t, fin_t + 1); end
    $display("back_to_back: second pass=%b", pass);
  endtask

  task automatic test_abort();
    int seen_done;
    start = 1'b1; window = CW'(10); valid_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < DLY + 4; i++) begin
      gold_in = $urandom; gate_in = ~gold_in; xmask_in = '0;
      @(posedge clk); #1;
    end
    rst = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if ({busy, done, pass} !== 3'b000 || fail_chan !== '0 || mismatch_count !== '0) begin n_err++; $display("FAIL abort_reset flags=%b fail=%b cnt=%0d exp 0", {busy, done, pass}, fail_chan, mismatch_count); end
    seen_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    n_vec++; if (seen_done !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
    clear_tabs();
    run(10, 0, 0, 1'b0);
    n_vec++; if (pass !== 1'b1 || done_t !== fin_t + 1) begin n_err++; $display("FAIL abort_rerun pass=%b done_t=%0d exp 1/%0d", pass, done_t, fin_t + 1); end
    $display("abort: rerun pass=%b", pass);
  endtask

  task automatic test_saturate();
    run(70000, 0, 3, 1'b0);
    n_vec++; if (mismatch_count !== m_cnt) begin n_err++; $display("FAIL saturate_count got=%h exp=%h", mismatch_count, m_cnt); end
    n_vec++; if (done_t !== fin_t + 1) begin n_err++; $display("FAIL saturate_done got=%0d exp=%0d", done_t, fin_t + 1); end
    $display("saturate: count=%h", mismatch_count);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_flips();
    test_xmask();
    test_window0();
    test_valid_toggle();
    test_start_in_run();
    test_random();
    test_back_to_back();
    test_abort();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
